// File: rtl/feature_map_readout_if.sv
// Bundles the pipeline-write and host-read signals of feature_map_readout.
// The master side is the pipeline/host; the slave side is the readout block.
interface feature_map_readout_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data_0;
    logic [DATA_W-1:0] in_data_1;
    logic              rd_req;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_ready;
    logic              overflow;

    modport master (
        output in_valid, in_data_0, in_data_1, rd_req,
        input  out_data, out_valid, frame_ready, overflow
    );

    modport slave (
        input  in_valid, in_data_0, in_data_1, rd_req,
        output out_data, out_valid, frame_ready, overflow
    );
endinterface

// File: rtl/feature_map_readout.sv
// Buffers one 2-channel feature-map frame and lets a host drain it byte by byte.
// Optional macro READOUT_CHECKSUM_EN appends a mod-256 sum byte after the frame.
module feature_map_readout #(
    parameter int NUM_POS = 36,
    parameter int DATA_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    feature_map_readout_if.slave bus
);
    localparam int NBYTES = 2 * NUM_POS;
    localparam int PTR_W  = $clog2(NUM_POS);
    localparam int ADDR_W = PTR_W + 1;
    localparam int IDX_W  = $clog2(NBYTES + 2);

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_READY   = 2'd1,
        S_READOUT = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_wr_ptr, w_wr_ptr_nxt;
    logic [IDX_W-1:0]    r_rd_idx, w_rd_idx_nxt;
    logic [DATA_W-1:0]   r_out_data, w_out_data_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic                r_frame_ready, w_frame_ready_nxt;
    logic                r_overflow, w_overflow_nxt;
    logic                r_sync1, r_sync2, r_sync3;
    logic                w_rd_edge;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [DATA_W-1:0]   r_mem [NBYTES];
`ifdef READOUT_CHECKSUM_EN
    logic [DATA_W-1:0]   r_csum, w_csum_nxt;
`endif

    // rd_req is asynchronous to clk: two flops to resolve metastability, a third for the edge
    assign w_rd_edge = r_sync2 & ~r_sync3;
    assign w_rd_addr = r_rd_idx[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.rd_req;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_ptr, 1'b0}] <= bus.in_data_0;
            r_mem[{r_wr_ptr, 1'b1}] <= bus.in_data_1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_rd_idx_nxt      = r_rd_idx;
        w_out_data_nxt    = r_out_data;
        w_out_valid_nxt   = r_out_valid;
        w_frame_ready_nxt = r_frame_ready;
        w_overflow_nxt    = r_overflow;
        w_wr_en           = 1'b0;
`ifdef READOUT_CHECKSUM_EN
        w_csum_nxt        = r_csum;
`endif
        case (r_state)
            S_CAPTURE: begin
                if (bus.in_valid) begin
                    w_wr_en = 1'b1;
`ifdef READOUT_CHECKSUM_EN
                    w_csum_nxt = r_csum + bus.in_data_0 + bus.in_data_1;
`endif
                    if (r_wr_ptr == PTR_W'(NUM_POS - 1)) begin
                        w_wr_ptr_nxt      = '0;
                        w_state_nxt       = S_READY;
                        w_frame_ready_nxt = 1'b1;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                    end
                end
            end
            S_READY: begin
                if (bus.in_valid) w_overflow_nxt = 1'b1;
                if (w_rd_edge) begin
                    w_out_data_nxt  = r_mem[0];
                    w_out_valid_nxt = 1'b1;
                    w_rd_idx_nxt    = IDX_W'(1);
                    w_state_nxt     = S_READOUT;
                end
            end
            S_READOUT: begin
                if (bus.in_valid) w_overflow_nxt = 1'b1;
                if (w_rd_edge) begin
                    if (r_rd_idx < IDX_W'(NBYTES)) begin
                        w_out_data_nxt = r_mem[w_rd_addr];
                        w_rd_idx_nxt   = r_rd_idx + IDX_W'(1);
`ifdef READOUT_CHECKSUM_EN
                    end else if (r_rd_idx == IDX_W'(NBYTES)) begin
                        w_out_data_nxt = r_csum;
                        w_rd_idx_nxt   = IDX_W'(NBYTES + 1);
`endif
                    end else begin
                        // Frame fully read: release the buffer for the next capture
                        w_out_data_nxt    = '0;
                        w_out_valid_nxt   = 1'b0;
                        w_frame_ready_nxt = 1'b0;
                        w_rd_idx_nxt      = '0;
                        w_state_nxt       = S_CAPTURE;
`ifdef READOUT_CHECKSUM_EN
                        w_csum_nxt        = '0;
`endif
                    end
                end
            end
            default: w_state_nxt = S_CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_CAPTURE;
            r_wr_ptr      <= '0;
            r_rd_idx      <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_frame_ready <= 1'b0;
            r_overflow    <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            r_csum        <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_idx      <= w_rd_idx_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_frame_ready <= w_frame_ready_nxt;
            r_overflow    <= w_overflow_nxt;
`ifdef READOUT_CHECKSUM_EN
            r_csum        <= w_csum_nxt;
`endif
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.frame_ready = r_frame_ready;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_feature_map_readout.sv
// Directed testbench for feature_map_readout: fill, drain, hold, overflow and reset scenarios.
// Expected checksum values follow READOUT_CHECKSUM_EN when the macro is defined.
module tb_feature_map_readout;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    feature_map_readout_if #(.DATA_W(8)) bus ();

    feature_map_readout #(.NUM_POS(36), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data_0 = d0;
        bus.in_data_1 = d1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    // rd_req high for high_clks cycles, then low 4; samples outputs after the 2nd and 3rd edges
    task automatic rd_pulse(input int high_clks, output logic [7:0] d2, output logic v2,
                            output logic [7:0] d3, output logic v3);
        @(negedge clk);
        bus.rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        d2 = bus.out_data;
        v2 = bus.out_valid;
        @(negedge clk);
        d3 = bus.out_data;
        v3 = bus.out_valid;
        repeat (high_clks - 3) @(negedge clk);
        bus.rd_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_byte(input int k, input int b0, input int b1);
        return (k % 2 == 0) ? 8'((k / 2) + b0) : 8'((k / 2) + b1);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.out_data !== 8'd0 || bus.out_valid !== 1'b0 || bus.frame_ready !== 1'b0 ||
            bus.overflow !== 1'b0)
            $display("FAIL reset_state: data=%0d valid=%b ready=%b ovf=%b, required 0/0/0/0",
                     bus.out_data, bus.out_valid, bus.frame_ready, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_fill(input int b0, input int b1);
        for (int p = 0; p < 36; p++) begin
            push(8'(p + b0), 8'(p + b1));
            if (p == 34) begin
                n_checks++;
                if (bus.frame_ready !== 1'b0)
                    $display("FAIL fill_not_ready_early: frame_ready=%b, required 0", bus.frame_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (bus.frame_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL fill_ready: frame_ready=%b out_valid=%b, required 1/0",
                     bus.frame_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_overflow();
        push(8'hAA, 8'hAA);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.frame_ready !== 1'b1)
            $display("FAIL overflow_set: overflow=%b frame_ready=%b, required 1/1",
                     bus.overflow, bus.frame_ready);
        else n_pass++;
    endtask

    task automatic test_first_byte_latency(input int b0);
        logic [7:0] d2, d3;
        logic v2, v3;
        rd_pulse(4, d2, v2, d3, v3);
        n_checks++;
        if (v2 !== 1'b0)
            $display("FAIL latency_early: out_valid=%b after 2 edges, required 0", v2);
        else n_pass++;
        n_checks++;
        if (v3 !== 1'b1 || d3 !== 8'(b0))
            $display("FAIL first_byte: data=%0d valid=%b, required %0d/1", d3, v3, b0);
        else n_pass++;
    endtask

    task automatic test_drain(input int from, input int to, input int b0, input int b1);
        logic [7:0] d2, d3;
        logic v2, v3;
        for (int k = from; k <= to; k++) begin
            rd_pulse(4, d2, v2, d3, v3);
            n_checks++;
            if (v3 !== 1'b1 || d3 !== exp_byte(k, b0, b1))
                $display("FAIL drain_byte%0d: data=%0d valid=%b, required %0d/1",
                         k, d3, v3, exp_byte(k, b0, b1));
            else n_pass++;
        end
    endtask

    task automatic test_hold(input int k, input int b0, input int b1);
        logic [7:0] d2, d3;
        logic v2, v3;
        rd_pulse(20, d2, v2, d3, v3);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_byte(k, b0, b1))
            $display("FAIL hold_one_advance: data=%0d valid=%b, required %0d/1",
                     bus.out_data, bus.out_valid, exp_byte(k, b0, b1));
        else n_pass++;
    endtask

    task automatic test_exit(input logic [7:0] csum, input logic ovf_exp);
        logic [7:0] d2, d3;
        logic v2, v3;
`ifdef READOUT_CHECKSUM_EN
        rd_pulse(4, d2, v2, d3, v3);
        n_checks++;
        if (v3 !== 1'b1 || d3 !== csum)
            $display("FAIL checksum_byte: data=%0d valid=%b, required %0d/1", d3, v3, csum);
        else n_pass++;
`endif
        rd_pulse(4, d2, v2, d3, v3);
        n_checks++;
        if (v3 !== 1'b0 || d3 !== 8'd0 || bus.frame_ready !== 1'b0 || bus.overflow !== ovf_exp)
            $display("FAIL exit: data=%0d valid=%b ready=%b ovf=%b, required 0/0/0/%b (csum %0d)",
                     d3, v3, bus.frame_ready, bus.overflow, ovf_exp, csum);
        else n_pass++;
    endtask

    task automatic test_capture_ignore();
        logic [7:0] d2, d3;
        logic v2, v3;
        for (int i = 0; i < 2; i++) begin
            rd_pulse(4, d2, v2, d3, v3);
            n_checks++;
            if (v3 !== 1'b0 || d3 !== 8'd0 || bus.frame_ready !== 1'b0)
                $display("FAIL capture_ignore%0d: data=%0d valid=%b ready=%b, required 0/0/0",
                         i, d3, v3, bus.frame_ready);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        test_fill(0, 100);
        test_first_byte_latency(0);
        test_drain(1, 9, 0, 100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.out_data !== 8'd0 || bus.out_valid !== 1'b0 || bus.frame_ready !== 1'b0 ||
            bus.overflow !== 1'b0)
            $display("FAIL reset_mid: data=%0d valid=%b ready=%b ovf=%b, required 0/0/0/0",
                     bus.out_data, bus.out_valid, bus.frame_ready, bus.overflow);
        else n_pass++;
        test_fill(50, 150);
        test_first_byte_latency(50);
        test_drain(1, 71, 50, 150);
        test_exit(8'd12, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data_0 = 8'd0;
        bus.in_data_1 = 8'd0;
        bus.rd_req    = 1'b0;
        test_reset();
        test_fill(0, 100);
        test_overflow();
        test_first_byte_latency(0);
        test_drain(1, 9, 0, 100);
        test_hold(10, 0, 100);
        test_drain(11, 71, 0, 100);
        test_exit(8'd252, 1'b1);
        test_capture_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
